// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised accumulator CPU with internal sequencer and a ready-handshake memory port
module cpu_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  go,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  halt,
    output logic                  instr_done,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  carry
);
    if (DATA_WIDTH < ADDR_WIDTH + 3) begin : g_width_check
        $error("DATA_WIDTH must be at least ADDR_WIDTH+3");
    end
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OPRD, OPWR, HALTED} state_t;
    typedef enum logic [2:0] {OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP} opcode_t;
    state_t                state;
    opcode_t               op;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] opnd;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH:0]   sum;
    logic                  zero;
    logic                  operand_phase;
    // ir is kept as its two live fields; the bits between them never reach any logic
    assign sum           = {1'b0, acc} + {1'b0, mem_rdata};
    assign zero          = (acc == '0);
    assign operand_phase = (state == OPRD) || (state == OPWR);
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            op    <= OP_HLT;
            opnd  <= '0;
            pc    <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= FETCH;
                FETCH: if (mem_ready) begin
                    op    <= opcode_t'(mem_rdata[DATA_WIDTH-1 -: 3]);
                    opnd  <= mem_rdata[ADDR_WIDTH-1:0];
                    pc    <= pc + ADDR_WIDTH'(1);
                    state <= EXEC;
                end
                EXEC: unique case (op)
                    OP_HLT: state <= HALTED;
                    OP_SKZ: begin
                        pc    <= zero ? pc + ADDR_WIDTH'(1) : pc;
                        state <= FETCH;
                    end
                    OP_JMP: begin
                        pc    <= opnd;
                        state <= FETCH;
                    end
                    OP_STO: state <= OPWR;
                    default: state <= OPRD;
                endcase
                OPRD: if (mem_ready) begin
                    unique case (op)
                        OP_ADD: {carry, acc} <= sum;
                        OP_AND: acc <= acc & mem_rdata;
                        OP_XOR: acc <= acc ^ mem_rdata;
                        default: acc <= mem_rdata;
                    endcase
                    state <= FETCH;
                end
                OPWR: state <= mem_ready ? FETCH : OPWR;
                HALTED: state <= go ? FETCH : HALTED;
                default: state <= IDLE;
            endcase
        end
    end
    assign mem_rd     = (state == FETCH) || (state == OPRD);
    assign mem_wr     = (state == OPWR);
    assign mem_addr   = (state == FETCH) ? pc : operand_phase ? opnd : '0;
    assign mem_wdata  = acc;
    assign halt       = (state == HALTED);
    assign instr_done = ((state == EXEC) && (op == OP_HLT || op == OP_SKZ || op == OP_JMP))
                      || (operand_phase && mem_ready);
    assign acc_out    = acc;
    assign pc_out     = pc;
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed programs checked against an instruction-level model of the core
module tb_cpu_core_param;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic go = 1'b0;
    logic go16 = 1'b0;
    logic stall = 1'b0;
    int   nwait = 0;
    int   wcnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;

    logic [4:0] a8, pc8;
    logic [7:0] wd8, rdat8, acc8;
    logic       rd8, wr8, rdy8, halt8, done8, c8;
    logic [7:0] mem [32];
    logic [7:0] mmem [32];
    assign rdy8  = stall ? 1'b0 : (rd8 | wr8) ? (wcnt == nwait) : 1'b1;
    assign rdat8 = mem[a8];
    always @(posedge clk) begin
        wcnt <= ((rd8 | wr8) && !rdy8) ? wcnt + 1 : 0;
        if (wr8 && rdy8) mem[a8] = wd8;
    end
    cpu_core_param dut8 (
        .clk(clk), .rst_(rst_), .go(go), .mem_addr(a8), .mem_rd(rd8), .mem_wr(wr8),
        .mem_wdata(wd8), .mem_rdata(rdat8), .mem_ready(rdy8), .halt(halt8),
        .instr_done(done8), .acc_out(acc8), .pc_out(pc8), .carry(c8)
    );

    logic [7:0]  a16, pc16;
    logic [15:0] wd16, rdat16, acc16;
    logic        rd16, wr16, halt16, done16, c16;
    logic [15:0] mem16 [256];
    assign rdat16 = mem16[a16];
    always @(posedge clk) if (wr16) mem16[a16] = wd16;
    cpu_core_param #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut16 (
        .clk(clk), .rst_(rst_), .go(go16), .mem_addr(a16), .mem_rd(rd16), .mem_wr(wr16),
        .mem_wdata(wd16), .mem_rdata(rdat16), .mem_ready(1'b1), .halt(halt16),
        .instr_done(done16), .acc_out(acc16), .pc_out(pc16), .carry(c16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction-level model: one step per completed instruction, checked the cycle after
    logic [4:0] mpc;
    logic [7:0] macc, w;
    logic [8:0] s;
    logic       mc, mhalt, pending, first, skip_len, prev_req, prev_rdy;
    logic [6:0] prev_bus;
    int         cnt, elen;
    always @(negedge clk) begin
        if (!rst_) begin
            mpc = '0; macc = '0; mc = 1'b0; mhalt = 1'b0; pending = 1'b0;
            first = 1'b1; skip_len = 1'b0; cnt = 0; prev_req = 1'b0; prev_rdy = 1'b1; prev_bus = '0;
        end else begin
            cnt++;
            check("rd_wr_exclusive", 32'(rd8 & wr8), 32'd0);
            if (prev_req && !prev_rdy) check("stall_hold", 32'({rd8, wr8, a8}), 32'(prev_bus));
            if (pending) begin
                pending = 1'b0;
                check("model_acc", 32'(acc8), 32'(macc));
                check("model_pc", 32'(pc8), 32'(mpc));
                check("model_carry", 32'(c8), 32'(mc));
                check("model_halt", 32'(halt8), 32'(mhalt));
                if (mhalt) check("halt_no_req", 32'({rd8, wr8}), 32'd0);
                else check("next_fetch", 32'({rd8, wr8, a8}), 32'({2'b10, mpc}));
            end
            if (done8) begin
                w = mmem[mpc];
                mpc = mpc + 5'd1;
                mhalt = 1'b0;
                elen = (w[7:5] == 3'd0 || w[7:5] == 3'd1 || w[7:5] == 3'd7) ? 2 + nwait : 3 + 2 * nwait;
                case (w[7:5])
                    3'd0: mhalt = 1'b1;
                    3'd1: if (macc == 8'd0) mpc = mpc + 5'd1;
                    3'd2: begin s = {1'b0, macc} + {1'b0, mmem[w[4:0]]}; macc = s[7:0]; mc = s[8]; end
                    3'd3: macc = macc & mmem[w[4:0]];
                    3'd4: macc = macc ^ mmem[w[4:0]];
                    3'd5: macc = mmem[w[4:0]];
                    3'd6: mmem[w[4:0]] = macc;
                    default: mpc = w[4:0];
                endcase
                if (!skip_len) check("instr_len", 32'(cnt), 32'(elen + (first ? 1 : 0)));
                first = 1'b0; skip_len = mhalt; cnt = 0; pending = 1'b1;
            end
            prev_req = rd8 | wr8; prev_rdy = rdy8; prev_bus = {rd8, wr8, a8};
        end
    end

    function automatic logic [7:0] e8(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction
    function automatic logic [15:0] e16(input logic [2:0] op, input logic [7:0] a);
        return {op, 5'd0, a};
    endfunction
    task automatic put8(input int a, input logic [7:0] v);
        mem[a] = v;
        mmem[a] = v;
    endtask
    task automatic start(input int waits);
        rst_ = 1'b0; go = 1'b0; go16 = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nwait = waits;
        for (int i = 0; i < 32; i++) begin mem[i] = '0; mmem[i] = '0; end
    endtask
    task automatic pulse_go;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask
    task automatic wait_halt8(input int maxc, output int cyc, output int dones);
        cyc = 0; dones = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (done8) dones++;
        end while (!halt8 && cyc < maxc);
        check("halt_reached", 32'(halt8), 32'd1);
    endtask
    task automatic load_basic;
        put8(0, e8(3'd5, 5'd10)); put8(1, e8(3'd2, 5'd11));
        put8(2, e8(3'd6, 5'd12)); put8(3, e8(3'd0, 5'd0));
        put8(10, 8'h05); put8(11, 8'h07);
    endtask

    int cyc, dones;
    initial begin
        #1;
        check("reset_outputs", 32'({rd8, wr8, halt8, done8, a8, acc8, pc8, c8}), 32'd0);
        start(0);
        load_basic();
        rst_ = 1'b1;
        wait_halt8(40, cyc, dones);
        check("basic_halt_cycles", 32'(cyc), 32'd12);
        check("basic_done_count", 32'(dones), 32'd4);
        check("basic_mem12", 32'(mem[12]), 32'h0C);
        check("basic_acc", 32'(acc8), 32'h0C);
        check("basic_pc", 32'(pc8), 32'd4);
        check("basic_carry", 32'(c8), 32'd0);

        start(0);
        put8(0, e8(3'd5, 5'd10)); put8(1, e8(3'd2, 5'd11)); put8(2, e8(3'd0, 5'd0));
        put8(3, e8(3'd2, 5'd12)); put8(4, e8(3'd0, 5'd0));
        put8(10, 8'hF0); put8(11, 8'h20); put8(12, 8'h01);
        rst_ = 1'b1;
        wait_halt8(40, cyc, dones);
        check("ovf_acc", 32'(acc8), 32'h10);
        check("ovf_carry", 32'(c8), 32'd1);
        pulse_go();
        wait_halt8(40, cyc, dones);
        check("ovf_next_acc", 32'(acc8), 32'h11);
        check("ovf_next_carry", 32'(c8), 32'd0);
        check("ovf_next_pc", 32'(pc8), 32'd5);

        start(0);
        put8(0, e8(3'd5, 5'd20)); put8(1, e8(3'd1, 5'd0)); put8(2, e8(3'd5, 5'd21));
        put8(3, e8(3'd0, 5'd0)); put8(4, e8(3'd5, 5'd22)); put8(5, e8(3'd1, 5'd0));
        put8(6, e8(3'd5, 5'd21)); put8(7, e8(3'd0, 5'd0));
        put8(21, 8'h55); put8(22, 8'h01);
        rst_ = 1'b1;
        wait_halt8(40, cyc, dones);
        check("skz_taken_acc", 32'(acc8), 32'h00);
        check("skz_taken_pc", 32'(pc8), 32'd4);
        pulse_go();
        wait_halt8(40, cyc, dones);
        check("skz_not_taken_acc", 32'(acc8), 32'h55);
        check("skz_not_taken_pc", 32'(pc8), 32'd8);

        start(0);
        put8(0, e8(3'd7, 5'd30)); put8(30, e8(3'd5, 5'd20)); put8(31, e8(3'd1, 5'd0));
        put8(1, e8(3'd0, 5'd0));
        rst_ = 1'b1;
        wait_halt8(40, cyc, dones);
        check("skz_wrap_pc", 32'(pc8), 32'd2);
        check("skz_wrap_acc", 32'(acc8), 32'h00);

        start(3);
        load_basic();
        rst_ = 1'b1;
        wait_halt8(100, cyc, dones);
        check("wait_halt_cycles", 32'(cyc), 32'd33);
        check("wait_done_count", 32'(dones), 32'd4);
        check("wait_mem12", 32'(mem[12]), 32'h0C);
        check("wait_acc", 32'(acc8), 32'h0C);

        start(0);
        put8(0, e8(3'd5, 5'd20)); put8(1, e8(3'd2, 5'd21)); put8(2, e8(3'd0, 5'd0));
        put8(3, e8(3'd7, 5'd0)); put8(20, 8'h03); put8(21, 8'h04);
        rst_ = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!(done8 && !rd8 && !wr8) && cyc < 40);
        check("hlt_exec_seen", 32'({done8, rd8, wr8}), 32'b100);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("go_in_exec_ignored", 32'(halt8), 32'd1);
        check("halted_pc", 32'(pc8), 32'd3);
        check("halted_acc", 32'(acc8), 32'h07);
        @(posedge clk); #1;
        check("halt_holds", 32'(halt8), 32'd1);
        put8(20, 8'h10);
        pulse_go();
        check("resume_halt_low", 32'(halt8), 32'd0);
        check("resume_fetch", 32'({rd8, a8}), 32'({1'b1, 5'd3}));
        wait_halt8(40, cyc, dones);
        check("jmp_loop_pc", 32'(pc8), 32'd3);
        check("jmp_loop_acc", 32'(acc8), 32'h14);

        start(0);
        put8(0, e8(3'd5, 5'd10)); put8(1, e8(3'd6, 5'd12));
        put8(10, 8'h05); put8(12, 8'hAA);
        rst_ = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!wr8 && cyc < 20);
        stall = 1'b1;
        check("opwr_reached", 32'(wr8), 32'd1);
        @(posedge clk); #3;
        rst_ = 1'b0;
        #1;
        check("async_reset_outputs", 32'({rd8, wr8, halt8, done8, a8, pc8, c8}), 32'd0);
        check("async_reset_acc", 32'(acc8), 32'd0);
        @(posedge clk); #1;
        check("no_commit_mem12", 32'(mem[12]), 32'hAA);
        stall = 1'b0;
        rst_ = 1'b1;
        check("idle_after_release", 32'({rd8, wr8}), 32'd0);
        @(posedge clk); #1;
        check("first_fetch_after_release", 32'({rd8, a8}), 32'({1'b1, 5'd0}));
        wait_halt8(40, cyc, dones);
        check("after_reset_mem12", 32'(mem[12]), 32'h05);

        start(0);
        for (int i = 0; i < 256; i++) mem16[i] = '0;
        mem16[0] = e16(3'd7, 8'd200);
        mem16[200] = e16(3'd5, 8'd240); mem16[201] = e16(3'd2, 8'd241);
        mem16[202] = e16(3'd6, 8'd242); mem16[203] = e16(3'd0, 8'd0);
        mem16[204] = e16(3'd5, 8'd243); mem16[205] = e16(3'd2, 8'd244);
        mem16[206] = e16(3'd0, 8'd0);
        mem16[240] = 16'h0005; mem16[241] = 16'h0007; mem16[243] = 16'hFFFF; mem16[244] = 16'h0001;
        rst_ = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!halt16 && cyc < 60);
        check("w16_halt", 32'(halt16), 32'd1);
        check("w16_mem242", 32'(mem16[242]), 32'h000C);
        check("w16_acc", 32'(acc16), 32'h000C);
        check("w16_pc", 32'(pc16), 32'd204);
        go16 = 1'b1;
        @(posedge clk); #1;
        go16 = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!halt16 && cyc < 60);
        check("w16_ovf_acc", 32'(acc16), 32'h0000);
        check("w16_ovf_carry", 32'(c16), 32'd1);
        check("w16_ovf_pc", 32'(pc16), 32'd207);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
